sfp_ctrl: RTL and testbench

Sequencer for the special-function stage between the output FIFO and the PSUM SRAM. Each job covers `len` consecutive PSUM rows starting at `base_addr`. For every row it pops one OFIFO entry, and in accumulate mode first reads the stored partial sum. It drives the SFP mode controls and writes the SFP result back to the same address. The SRAM is single-port, active-low enable, with 1-cycle read latency.

---
 rtl/sfp_ctrl.sv | 108 ++++++++++
 tb/tb_sfp_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sfp_ctrl.sv
// Row sequencer between the output FIFO and the PSUM SRAM: reads (accumulate mode),
// then writes each row back through the SFP, popping one OFIFO entry per row.
module sfp_ctrl #(
    parameter int unsigned addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               first_pass,
    input  logic               relu_en,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [addr_bw-1:0] len,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               psum_cen,
    output logic               psum_wen,
    output logic [addr_bw-1:0] psum_addr,
    output logic               sfp_passthrough,
    output logic               sfp_accum,
    output logic               sfp_relu,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [addr_bw-1:0] r_cnt;
    logic [addr_bw-1:0] r_base;
    logic [addr_bw-1:0] r_len;
    logic [addr_bw-1:0] r_addr_hold;
    logic               r_first;
    logic               r_relu;

    logic [addr_bw-1:0] w_addr;
    logic               w_rd_fire;
    logic               w_wr_fire;
    logic               w_last;

    assign w_addr    = r_base + r_cnt;
    assign w_rd_fire = (r_state == S_RD) && ofifo_valid;
    // Accumulate-mode WR always follows a read issued with the OFIFO head present.
    assign w_wr_fire = (r_state == S_WR) && (ofifo_valid || !r_first);
    assign w_last    = (r_cnt == r_len - addr_bw'(1));

    // State, row counter, latched job fields and last driven SRAM address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_addr_hold <= '0;
            r_first     <= 1'b0;
            r_relu      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_first <= first_pass;
                        r_relu  <= relu_en;
                        r_base  <= base_addr;
                        r_len   <= len;
                        r_cnt   <= '0;
                        if (len == '0)      r_state <= S_DONE;
                        else if (first_pass) r_state <= S_WR;
                        else                 r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (w_rd_fire) begin
                        r_addr_hold <= w_addr;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_wr_fire) begin
                        r_addr_hold <= w_addr;
                        r_cnt       <= r_cnt + addr_bw'(1);
                        if (w_last)       r_state <= S_DONE;
                        else if (r_first) r_state <= S_WR;
                        else              r_state <= S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from registered state and the live OFIFO valid
    always_comb begin
        psum_cen        = !(w_rd_fire || w_wr_fire);
        psum_wen        = !w_wr_fire;
        psum_addr       = (w_rd_fire || w_wr_fire) ? w_addr : r_addr_hold;
        ofifo_rd        = w_wr_fire;
        sfp_passthrough = w_wr_fire && r_first;
        sfp_accum       = w_wr_fire && !r_first;
        sfp_relu        = w_wr_fire && r_relu;
        busy            = (r_state != S_IDLE);
        done            = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_sfp_ctrl.sv
// Self-checking bench for sfp_ctrl: per-cycle vector table feeding a scoreboard
// queue, plus a hand-written mid-job reset sequence.
module tb_sfp_ctrl;

    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          first_pass = 1'b0;
    logic          relu_en = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic          ofifo_valid = 1'b0;
    logic          ofifo_rd;
    logic          psum_cen;
    logic          psum_wen;
    logic [AW-1:0] psum_addr;
    logic          sfp_passthrough;
    logic          sfp_accum;
    logic          sfp_relu;
    logic          busy;
    logic          done;

    sfp_ctrl #(.addr_bw(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .first_pass      (first_pass),
        .relu_en         (relu_en),
        .base_addr       (base_addr),
        .len             (len),
        .ofifo_valid     (ofifo_valid),
        .ofifo_rd        (ofifo_rd),
        .psum_cen        (psum_cen),
        .psum_wen        (psum_wen),
        .psum_addr       (psum_addr),
        .sfp_passthrough (sfp_passthrough),
        .sfp_accum       (sfp_accum),
        .sfp_relu        (sfp_relu),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            st;
        bit            fp;
        bit            rl;
        logic [AW-1:0] base;
        logic [AW-1:0] ln;
        bit            vld;
        logic [18:0]   exp;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          vec_idx = 0;

    function automatic logic [18:0] outs_now();
        return {psum_cen, psum_wen, psum_addr, ofifo_rd, sfp_passthrough,
                sfp_accum, sfp_relu, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One table row per cycle: inputs, then expected
    // {cen,wen,addr,rd,passthrough,accum,relu,busy,done}.
    task automatic v(input bit st, input bit fp, input bit rl, input int base, input int ln,
                     input bit vld, input bit cen, input bit wen, input int addr,
                     input bit rd, input bit pt, input bit ac, input bit ro,
                     input bit bz, input bit dn);
        vec_t e;
        e.st   = st;
        e.fp   = fp;
        e.rl   = rl;
        e.base = AW'(base);
        e.ln   = AW'(ln);
        e.vld  = vld;
        e.exp  = {cen, wen, AW'(addr), rd, pt, ac, ro, bz, dn};
        vecs.push_back(e);
    endtask

    // Scoreboard: pop one expected record per cycle while the table is running
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [18:0] e;
            e = sb_q.pop_front();
            check($sformatf("vec%0d", vec_idx), 32'(outs_now()), 32'(e));
            vec_idx++;
        end
    end

    initial begin
        // Accumulate job base 5 len 3 relu, with starts mid-job and on done ignored
        v(1,0,1,   5,3,1, 1,1,   5*0,0,0,0,0,0,0);
        v(0,0,1,   5,3,1, 0,1,   5,0,0,0,0,1,0);
        v(0,0,1,   5,3,1, 0,0,   5,1,0,1,1,1,0);
        v(1,1,0, 100,1,1, 0,1,   6,0,0,0,0,1,0);
        v(0,0,1,   5,3,1, 0,0,   6,1,0,1,1,1,0);
        v(0,0,1,   5,3,1, 0,1,   7,0,0,0,0,1,0);
        v(0,0,1,   5,3,1, 0,0,   7,1,0,1,1,1,0);
        v(1,1,0, 100,1,1, 1,1,   7,0,0,0,0,1,1);
        // Start one cycle after done: passthrough base 10 len 4, stall in cycle 2
        v(1,1,0,  10,4,1, 1,1,   7,0,0,0,0,0,0);
        v(0,1,0,  10,4,1, 0,0,  10,1,1,0,0,1,0);
        v(0,1,0,  10,4,1, 0,0,  11,1,1,0,0,1,0);
        v(0,1,0,  10,4,0, 1,1,  11,0,0,0,0,1,0);
        v(0,1,0,  10,4,1, 0,0,  12,1,1,0,0,1,0);
        v(0,1,0,  10,4,1, 0,0,  13,1,1,0,0,1,0);
        v(0,1,0,  10,4,1, 1,1,  13,0,0,0,0,1,1);
        // Wrap-around passthrough with relu
        v(1,1,1,2046,3,1, 1,1,  13,0,0,0,0,0,0);
        v(0,1,1,2046,3,1, 0,0,2046,1,1,0,1,1,0);
        v(0,1,1,2046,3,1, 0,0,2047,1,1,0,1,1,0);
        v(0,1,1,2046,3,1, 0,0,   0,1,1,0,1,1,0);
        v(0,1,1,2046,3,1, 1,1,   0,0,0,0,0,1,1);
        // Zero-length job
        v(1,0,0, 500,0,1, 1,1,   0,0,0,0,0,0,0);
        v(0,0,0, 500,0,1, 1,1,   0,0,0,0,0,1,1);
        // Accumulate with an OFIFO stall in RD
        v(1,0,0,   3,1,1, 1,1,   0,0,0,0,0,0,0);
        v(0,0,0,   3,1,0, 1,1,   0,0,0,0,0,1,0);
        v(0,0,0,   3,1,1, 0,1,   3,0,0,0,0,1,0);
        v(0,0,0,   3,1,1, 0,0,   3,1,0,1,0,1,0);
        v(0,0,0,   3,1,1, 1,1,   3,0,0,0,0,1,1);
        v(0,0,0,   3,1,1, 1,1,   3,0,0,0,0,0,0);

        // Reset state, checked with no clock edge while held
        #12;
        check("reset_outs", 32'(outs_now()), 32'({1'b1, 1'b1, AW'(0), 6'b0}));
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            start       = vecs[i].st;
            first_pass  = vecs[i].fp;
            relu_en     = vecs[i].rl;
            base_addr   = vecs[i].base;
            len         = vecs[i].ln;
            ofifo_valid = vecs[i].vld;
            sb_q.push_back(vecs[i].exp);
        end
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Reset in the middle of a passthrough job
        #1;
        start = 1'b1; first_pass = 1'b1; relu_en = 1'b0;
        base_addr = AW'(40); len = AW'(5); ofifo_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3;
        check("pre_reset_cen", 32'(psum_cen), 32'd0);
        check("pre_reset_addr", 32'(psum_addr), 32'd41);
        #1 reset = 1'b0;
        #1;
        check("rst_cen", 32'(psum_cen), 32'd1);
        check("rst_rd", 32'(ofifo_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(psum_addr), 32'd0);
        #2 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", k),
                  32'({psum_cen, ofifo_rd, busy, done}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
        end
        // Fresh job after reset release
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(9); len = AW'(1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("fresh_write", 32'({psum_cen, psum_wen, psum_addr, sfp_passthrough}),
              32'({1'b0, 1'b0, AW'(9), 1'b1}));
        @(negedge clk);
        check("fresh_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
